// File: rtl/dsp48a1_slice_pkg.sv
// Shared definitions for the DSP48A1-style MAC slice: OPMODE field positions
// and the X/Z operand select encodings.
package dsp48a1_slice_pkg;

    localparam int OP_W      = 8;
    localparam int OP_SUB    = 7;
    localparam int OP_PRESUB = 6;
    localparam int OP_CIN    = 5;
    localparam int OP_PREUSE = 4;
    localparam int OP_Z_HI   = 3;
    localparam int OP_Z_LO   = 2;
    localparam int OP_X_HI   = 1;
    localparam int OP_X_LO   = 0;

    localparam int AB_W = 18;
    localparam int M_W  = 36;
    localparam int P_W  = 48;

    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_DAB  = 2'b11
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'b00,
        Z_PCIN = 2'b01,
        Z_P    = 2'b10,
        Z_C    = 2'b11
    } z_sel_e;

endpackage

// File: rtl/dsp48a1_slice_stage.sv
// One pipeline stage of the slice: a CE-gated register with async clear when
// REG=1, a plain wire-through when REG=0.
module dsp_stage_reg #(
    parameter int WIDTH = 1,
    parameter bit REG   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (REG) begin : g_reg
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_q <= '0;
                else if (ce)
                    r_q <= d;
            end
            assign q = r_q;
        end else begin : g_bypass
            // clock, reset and enable are irrelevant for a bypassed stage
            logic w_unused_bypass;
            assign w_unused_bypass = &{1'b0, clk, rst_n, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp48a1_slice.sv
// Pipelined 18x18 MAC slice: pre-adder, multiplier, 48-bit post-adder with
// X/Z operand muxes, carry chain and B/P cascade, every stage optional.
module dsp48a1_slice
    import dsp48a1_slice_pkg::*;
#(
    parameter bit A0REG       = 1'b0,
    parameter bit A1REG       = 1'b1,
    parameter bit B0REG       = 1'b0,
    parameter bit B1REG       = 1'b1,
    parameter bit CREG        = 1'b1,
    parameter bit DREG        = 1'b1,
    parameter bit MREG        = 1'b1,
    parameter bit PREG        = 1'b1,
    parameter bit CARRYINREG  = 1'b1,
    parameter bit CARRYOUTREG = 1'b1,
    parameter bit OPMODEREG   = 1'b1,
    parameter     CARRYINSEL  = "OPMODE5",
    parameter     B_INPUT     = "DIRECT"
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AB_W-1:0] A,
    input  logic [AB_W-1:0] B,
    input  logic [AB_W-1:0] D,
    input  logic [AB_W-1:0] BCIN,
    input  logic [P_W-1:0]  C,
    input  logic [P_W-1:0]  PCIN,
    input  logic            CARRYIN,
    input  logic [OP_W-1:0] OPMODE,
    input  logic            CEA,
    input  logic            CEB,
    input  logic            CEC,
    input  logic            CED,
    input  logic            CEM,
    input  logic            CEP,
    input  logic            CECARRYIN,
    input  logic            CEOPMODE,
    output logic [AB_W-1:0] BCOUT,
    output logic [M_W-1:0]  M,
    output logic [P_W-1:0]  P,
    output logic [P_W-1:0]  PCOUT,
    output logic            CARRYOUT,
    output logic            CARRYOUTF
);

    localparam bit USE_BCIN    = (B_INPUT == "CASCADE");
    localparam bit CIN_FROM_OP = (CARRYINSEL == "OPMODE5");

    logic [OP_W-1:0] w_op;
    logic [AB_W-1:0] w_a0, w_a1, w_b_src, w_b0, w_b1, w_d, w_preadd, w_b1_d;
    logic [P_W-1:0]  w_c, w_p, w_x, w_z;
    logic [M_W-1:0]  w_mult, w_m;
    logic            w_cin_d, w_cin, w_co;
    logic [P_W:0]    w_xcin, w_sum;

    // ---------------- input stages ----------------
    dsp_stage_reg #(.WIDTH(OP_W), .REG(OPMODEREG)) u_opmode (
        .clk(clk), .rst_n(rst_n), .ce(CEOPMODE), .d(OPMODE), .q(w_op));

    dsp_stage_reg #(.WIDTH(AB_W), .REG(A0REG)) u_a0 (
        .clk(clk), .rst_n(rst_n), .ce(CEA), .d(A), .q(w_a0));

    dsp_stage_reg #(.WIDTH(AB_W), .REG(A1REG)) u_a1 (
        .clk(clk), .rst_n(rst_n), .ce(CEA), .d(w_a0), .q(w_a1));

    assign w_b_src = USE_BCIN ? BCIN : B;

    dsp_stage_reg #(.WIDTH(AB_W), .REG(B0REG)) u_b0 (
        .clk(clk), .rst_n(rst_n), .ce(CEB), .d(w_b_src), .q(w_b0));

    dsp_stage_reg #(.WIDTH(AB_W), .REG(DREG)) u_d (
        .clk(clk), .rst_n(rst_n), .ce(CED), .d(D), .q(w_d));

    dsp_stage_reg #(.WIDTH(P_W), .REG(CREG)) u_c (
        .clk(clk), .rst_n(rst_n), .ce(CEC), .d(C), .q(w_c));

    // ---------------- pre-adder and B1 ----------------
    assign w_preadd = w_op[OP_PRESUB] ? (w_d - w_b0) : (w_d + w_b0);
    assign w_b1_d   = w_op[OP_PREUSE] ? w_preadd : w_b0;

    dsp_stage_reg #(.WIDTH(AB_W), .REG(B1REG)) u_b1 (
        .clk(clk), .rst_n(rst_n), .ce(CEB), .d(w_b1_d), .q(w_b1));

    // ---------------- multiplier ----------------
    assign w_mult = M_W'(w_a1) * M_W'(w_b1);

    dsp_stage_reg #(.WIDTH(M_W), .REG(MREG)) u_m (
        .clk(clk), .rst_n(rst_n), .ce(CEM), .d(w_mult), .q(w_m));

    // ---------------- carry-in ----------------
    assign w_cin_d = CIN_FROM_OP ? w_op[OP_CIN] : CARRYIN;

    dsp_stage_reg #(.WIDTH(1), .REG(CARRYINREG)) u_cin (
        .clk(clk), .rst_n(rst_n), .ce(CECARRYIN), .d(w_cin_d), .q(w_cin));

    // ---------------- X / Z operand muxes ----------------
    always_comb begin
        w_x = '0;
        case (x_sel_e'(w_op[OP_X_HI:OP_X_LO]))
            X_ZERO: w_x = '0;
            X_M:    w_x = {{(P_W-M_W){1'b0}}, w_m};
            X_P:    w_x = w_p;
            X_DAB:  w_x = {w_d[11:0], w_a1, w_b1};
            default: w_x = '0;
        endcase
    end

    always_comb begin
        w_z = '0;
        case (z_sel_e'(w_op[OP_Z_HI:OP_Z_LO]))
            Z_ZERO: w_z = '0;
            Z_PCIN: w_z = PCIN;
            Z_P:    w_z = w_p;
            Z_C:    w_z = w_c;
            default: w_z = '0;
        endcase
    end

    // ---------------- post-adder ----------------
    // 49-bit math: bit 48 is carry on add and borrow on subtract
    assign w_xcin = {1'b0, w_x} + (P_W+1)'(w_cin);
    assign w_sum  = w_op[OP_SUB] ? ({1'b0, w_z} - w_xcin) : ({1'b0, w_z} + w_xcin);

    dsp_stage_reg #(.WIDTH(P_W), .REG(PREG)) u_p (
        .clk(clk), .rst_n(rst_n), .ce(CEP), .d(w_sum[P_W-1:0]), .q(w_p));

    dsp_stage_reg #(.WIDTH(1), .REG(CARRYOUTREG)) u_co (
        .clk(clk), .rst_n(rst_n), .ce(CEP), .d(w_sum[P_W]), .q(w_co));

    // ---------------- outputs ----------------
    assign BCOUT     = w_b1;
    assign M         = w_m;
    assign P         = w_p;
    assign PCOUT     = w_p;
    assign CARRYOUT  = w_co;
    assign CARRYOUTF = w_co;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Directed bench for dsp48a1_slice: expected values are queued with each
// stimulus step and popped against the DUT outputs after the pipeline delay.
module tb_dsp48a1_slice;

    logic        clk;
    logic        rst_n;
    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [17:0] BCOUT;
    logic [35:0] M;
    logic [47:0] P, PCOUT;
    logic        CARRYOUT, CARRYOUTF;

    typedef enum int {S_BCOUT, S_M, S_P, S_PCOUT, S_CO, S_COF} sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [47:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    dsp48a1_slice dut (
        .clk(clk), .rst_n(rst_n),
        .A(A), .B(B), .D(D), .BCIN(BCIN),
        .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
        .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
        .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] observe(sig_e s);
        case (s)
            S_BCOUT: return {30'd0, BCOUT};
            S_M:     return {12'd0, M};
            S_P:     return P;
            S_PCOUT: return PCOUT;
            S_CO:    return {47'd0, CARRYOUT};
            S_COF:   return {47'd0, CARRYOUTF};
            default: return 48'hx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input sig_e s, input logic [47:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // advance n rising edges, then sample on the falling edge and drain the queue
    task automatic step_and_check(input int n);
        exp_t        e;
        logic [47:0] obs;
        repeat (n) @(posedge clk);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.sig);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        A = 18'($urandom); B = 18'($urandom); D = 18'($urandom); BCIN = 18'($urandom);
        C = {16'($urandom), 32'($urandom)}; PCIN = {16'($urandom), 32'($urandom)};
        CARRYIN = 1'($urandom); OPMODE = 8'($urandom);
        {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = 8'hFF;

        // reset holds every output at zero regardless of inputs
        expect_val("rst_p", S_P, 48'd0);
        expect_val("rst_pcout", S_PCOUT, 48'd0);
        expect_val("rst_bcout", S_BCOUT, 48'd0);
        expect_val("rst_m", S_M, 48'd0);
        expect_val("rst_co", S_CO, 48'd0);
        expect_val("rst_cof", S_COF, 48'd0);
        step_and_check(3);
        rst_n = 1'b1;

        // C - M with pre-subtract: B1 = 25-10, M = 20*15, P = 350-300
        A = 18'd20; B = 18'd10; C = 48'd350; D = 18'd25; PCIN = 48'd0; CARRYIN = 1'b0;
        OPMODE = 8'b11011101;
        expect_val("t1_bcout", S_BCOUT, 48'hF);
        expect_val("t1_m", S_M, 48'h12C);
        expect_val("t1_p", S_P, 48'h32);
        expect_val("t1_pcout", S_PCOUT, 48'h32);
        expect_val("t1_co", S_CO, 48'd0);
        step_and_check(4);

        // pre-add into B1, X=Z=0
        OPMODE = 8'b00010000;
        expect_val("t2_bcout", S_BCOUT, 48'h23);
        expect_val("t2_m", S_M, 48'h2BC);
        expect_val("t2_p", S_P, 48'd0);
        expect_val("t2_co", S_CO, 48'd0);
        step_and_check(3);

        // P + P starting from zero stays zero; B1 takes B0 directly
        OPMODE = 8'b00001010;
        expect_val("t3_bcout", S_BCOUT, 48'hA);
        expect_val("t3_m", S_M, 48'hC8);
        expect_val("t3_p", S_P, 48'd0);
        step_and_check(3);

        // PCIN - ({D,A,B} + 1) borrows
        A = 18'd5; B = 18'd6; D = 18'd25; PCIN = 48'd3000;
        OPMODE = 8'b10100111;
        expect_val("t4_bcout", S_BCOUT, 48'd6);
        expect_val("t4_m", S_M, 48'h1E);
        expect_val("t4_p", S_P, 48'hFE6F_FFEC_0BB1);
        expect_val("t4_pcout", S_PCOUT, 48'hFE6F_FFEC_0BB1);
        expect_val("t4_co", S_CO, 48'd1);
        expect_val("t4_cof", S_COF, 48'd1);
        step_and_check(3);

        // pre-subtract wraps (5-10), C + 1 overflows to 0 with carry
        A = 18'd1; B = 18'd10; D = 18'd5; C = 48'hFFFF_FFFF_FFFF;
        OPMODE = 8'b01111100;
        expect_val("t5_bcout_wrap", S_BCOUT, 48'h3FFFB);
        expect_val("t5_m_wrap", S_M, 48'h3FFFB);
        expect_val("t5_p_ovf", S_P, 48'd0);
        expect_val("t5_co_ovf", S_CO, 48'd1);
        step_and_check(3);

        // accumulate P += M from a fresh reset: M=12, P reaches 24 after 4 edges
        @(negedge clk);
        rst_n = 1'b0;
        A = 18'd3; B = 18'd4; D = 18'd0; C = 48'd0; PCIN = 48'd0;
        OPMODE = 8'b00001001;
        #1 rst_n = 1'b1;
        expect_val("acc_m", S_M, 48'd12);
        expect_val("acc_p", S_P, 48'd24);
        step_and_check(4);

        // freeze P while M keeps moving
        CEP = 1'b0;
        A = 18'd5;
        expect_val("hold_p", S_P, 48'd24);
        expect_val("hold_m", S_M, 48'd20);
        step_and_check(3);

        // re-enable: one more accumulation of the new M
        CEP = 1'b1;
        expect_val("resume_p", S_P, 48'd44);
        step_and_check(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
